rf_writeback_arbiter: RTL and testbench
=======================================

// Module: rf_writeback_arbiter
// PURPOSE
//  Shares the register file's single write port between NUM_REQ writeback sources
//  (e.g. ALU, load unit, debug). Uses round-robin arbitration with a valid/ready handshake.
//  Drives RegWrite / rg_wrt_dest / rg_wrt_data through one output register stage.
//  Keeps a per-register busy scoreboard: issue sets a bit, the actual regfile write clears it.
// PARAMETERS
//  DATA_WIDTH     32  bits per register / write data width
//  ADDRESS_WIDTH  5   register address width
//  NUM_REGS       32  registers tracked by scoreboard (<= 2**ADDRESS_WIDTH)
//  NUM_REQ        3   number of writeback requesters (>= 2)
// PORTS
//  clk          in   1                      clock, all state on posedge
//  rst          in   1                      synchronous reset, active-high
//  req_valid    in   NUM_REQ                requester i has a write pending
//  req_dest     in   NUM_REQ*ADDRESS_WIDTH  dest of req i, slice [i*AW +: AW]
//  req_data     in   NUM_REQ*DATA_WIDTH     data of req i, slice [i*DW +: DW]
//  req_ready    out  NUM_REQ                one-hot grant; handshake = valid & ready
//  rsv_valid    in   1                      issue stage reserves a destination
//  rsv_dest     in   ADDRESS_WIDTH          register being reserved
//  busy         out  NUM_REGS               scoreboard: 1 = write outstanding
//  RegWrite     out  1                      write enable to register file
//  rg_wrt_dest  out  ADDRESS_WIDTH          write address to register file
//  rg_wrt_data  out  DATA_WIDTH             write data to register file
//  grant_id     out  $clog2(NUM_REQ)        index of requester behind current RegWrite
// BEHAVIOUR
//  - Reset (rst=1 at posedge): RegWrite=0, rg_wrt_dest=0, rg_wrt_data=0, grant_id=0,
//    busy=0, rr_ptr=0. Reset mid-transfer drops the registered write; no regfile write.
//  - Arbitration (combinational): search from rr_ptr upward, modulo NUM_REQ.
//    The first i with req_valid[i]=1 gets req_ready[i]=1; all others get 0.
//    No valid request: req_ready=0. req_ready is never asserted during rst.
//  - At most one grant per cycle. The port always accepts, so a valid request is granted
//    within NUM_REQ cycles (starvation-free).
//  - rr_ptr updates only on a handshake: rr_ptr <= (granted+1) mod NUM_REQ.
//    It holds when there is no request.
//  - Latency: handshake in cycle N gives RegWrite=1 plus the captured dest/data/grant_id
//    in cycle N+1, for exactly one cycle.
//    No handshake in cycle N: RegWrite=0 in N+1; dest/data/grant_id hold their values.
//  - Dest 0: handshake completes (ready=1), but RegWrite stays 0. x0 is never written.
//  - Requester rule: valid/dest/data stay stable until the handshake.
//    The arbiter may grant a different requester meanwhile.
//  - Scoreboard: rsv_valid with rsv_dest!=0 sets busy[rsv_dest] at the next edge.
//    A registered RegWrite=1 clears busy[rg_wrt_dest] at the next edge.
//    Same register set and cleared in one cycle: set wins (newer producer).
//    rsv_dest=0 is ignored; busy[0] is always 0.
//    Clearing a non-busy register is legal and has no effect.
//  - rsv_dest >= NUM_REGS is ignored.
// TESTING
//  1 Reset: drive all req_valid=1, rst=1 -> req_ready=0, RegWrite=0, busy=0.
//    After release, req0 is granted first.
//  2 All 3 valid continuously, dests 1/2/3 -> grants 0,1,2,0,... one per cycle.
//    RegWrite=1 each cycle, one cycle later, with matching dest/data/grant_id.
//  3 Only req1 valid (dest 5, data 0xDEADBEEF) -> ready1 same cycle.
//    Next cycle: RegWrite=1, dest=5, data=0xDEADBEEF, grant_id=1.
//  4 req2 with dest 0 -> ready2=1; next cycle RegWrite=0, rr_ptr advances to 0.
//  5 rsv dest 7 -> busy[7]=1. Writeback to 7 -> busy[7]=0 one cycle after RegWrite.
//    Reserve 7 in the same cycle as RegWrite to 7 -> busy[7] remains 1.
//  6 rst asserted in the cycle after a handshake -> RegWrite=0 next cycle, busy cleared.

Source files
------------

// File: rtl/rf_writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ writeback
// sources, with one registered output stage and a per-register busy scoreboard.
module rf_writeback_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int NUM_REQ       = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_dest,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             rsv_valid,
    input  logic [ADDRESS_WIDTH-1:0]         rsv_dest,
    output logic [NUM_REGS-1:0]              busy,
    output logic                             RegWrite,
    output logic [ADDRESS_WIDTH-1:0]         rg_wrt_dest,
    output logic [DATA_WIDTH-1:0]            rg_wrt_data,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id
);
    localparam int GW = $clog2(NUM_REQ);

    logic [GW-1:0]            rr_ptr;
    logic [GW-1:0]            gnt_idx;
    logic                     gnt_found;
    logic                     hs;
    logic [ADDRESS_WIDTH-1:0] sel_dest;
    logic [DATA_WIDTH-1:0]    sel_data;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[GW-1:0];
            end
        end
    end

    assign hs       = gnt_found && !rst;
    assign sel_dest = req_dest[int'(gnt_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign sel_data = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        req_ready = '0;
        if (hs) req_ready[gnt_idx] = 1'b1;
    end

    // A dest-0 grant is consumed but leaves the write port and its bus untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite    <= 1'b0;
            rg_wrt_dest <= '0;
            rg_wrt_data <= '0;
            grant_id    <= '0;
            rr_ptr      <= '0;
        end else begin
            RegWrite <= hs && (sel_dest != '0);
            if (hs) begin
                rr_ptr <= (gnt_idx == GW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                if (sel_dest != '0) begin
                    rg_wrt_dest <= sel_dest;
                    rg_wrt_data <= sel_data;
                    grant_id    <= gnt_idx;
                end
            end
        end
    end

    // Scoreboard: set from issue has priority over clear from the registered write.
    assign busy[0] = 1'b0;
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_busy
        logic set_bit, clr_bit;
        assign set_bit = rsv_valid && (rsv_dest == ADDRESS_WIDTH'(i));
        assign clr_bit = RegWrite && (rg_wrt_dest == ADDRESS_WIDTH'(i));
        always_ff @(posedge clk) begin
            if (rst)          busy[i] <= 1'b0;
            else if (set_bit) busy[i] <= 1'b1;
            else if (clr_bit) busy[i] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: arbitration vector table plus hand-written
// scoreboard and reset sequences.
module tb_rf_writeback_arbiter;
    localparam int DW = 32, AW = 5, NR = 32, NQ = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NQ-1:0]   req_valid;
    logic [NQ*AW-1:0] req_dest;
    logic [NQ*DW-1:0] req_data;
    logic [NQ-1:0]   req_ready;
    logic            rsv_valid;
    logic [AW-1:0]   rsv_dest;
    logic [NR-1:0]   busy;
    logic            RegWrite;
    logic [AW-1:0]   rg_wrt_dest;
    logic [DW-1:0]   rg_wrt_data;
    logic [1:0]      grant_id;

    int checks = 0;
    int failures = 0;

    rf_writeback_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR), .NUM_REQ(NQ)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_dest(req_dest), .req_data(req_data),
        .req_ready(req_ready), .rsv_valid(rsv_valid), .rsv_dest(rsv_dest), .busy(busy),
        .RegWrite(RegWrite), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  exp_ready;
        logic        exp_we;
        logic        chk_bus;
        logic [4:0]  exp_dest;
        logic [31:0] exp_data;
        logic [1:0]  exp_gid;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic [2:0] v, logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                                logic [2:0] er, logic ew, logic cb, logic [4:0] ed,
                                logic [31:0] edata, logic [1:0] eg);
        vec_t r;
        r.valid = v; r.a0 = a0; r.a1 = a1; r.a2 = a2;
        r.d0 = d0; r.d1 = d1; r.d2 = d2;
        r.exp_ready = er; r.exp_we = ew; r.chk_bus = cb;
        r.exp_dest = ed; r.exp_data = edata; r.exp_gid = eg;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2);
        req_valid = v;
        req_dest  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rr_ptr trace: 0 ->1 ->2 ->0 ->1 ->2 (hold) ->0 (dest 0) ->1 ->2 ->1 ->0
        vecs[0]  = mk(3'b111, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1, 1, 1, 32'hA0, 0);
        vecs[1]  = mk(3'b111, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1, 1, 2, 32'hA1, 1);
        vecs[2]  = mk(3'b111, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 3'b100, 1, 1, 3, 32'hA2, 2);
        vecs[3]  = mk(3'b111, 1, 2, 3, 32'hB0, 32'hB1, 32'hB2, 3'b001, 1, 1, 1, 32'hB0, 0);
        vecs[4]  = mk(3'b010, 0, 5, 0, 32'h0, 32'hDEADBEEF, 32'h0, 3'b010, 1, 1, 5, 32'hDEADBEEF, 1);
        vecs[5]  = mk(3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 1, 5, 32'hDEADBEEF, 1);
        vecs[6]  = mk(3'b100, 0, 0, 0, 32'h0, 32'h0, 32'h12345678, 3'b100, 0, 0, 0, 32'h0, 0);
        vecs[7]  = mk(3'b011, 4, 6, 0, 32'hC0, 32'hC1, 32'h0, 3'b001, 1, 1, 4, 32'hC0, 0);
        vecs[8]  = mk(3'b011, 4, 6, 0, 32'hC0, 32'hC1, 32'h0, 3'b010, 1, 1, 6, 32'hC1, 1);
        vecs[9]  = mk(3'b001, 8, 0, 0, 32'hD0, 32'h0, 32'h0, 3'b001, 1, 1, 8, 32'hD0, 0);
        vecs[10] = mk(3'b101, 9, 0, 10, 32'hE0, 32'h0, 32'hE2, 3'b100, 1, 1, 10, 32'hE2, 2);

        rsv_valid = 1'b0;
        rsv_dest  = '0;
        rst       = 1'b1;
        drive(3'b111, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2);
        step();
        step();
        chk("reset_ready", 64'(req_ready), 64'(3'b000));
        chk("reset_we", 64'(RegWrite), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_dest", 64'(rg_wrt_dest), 64'(0));
        chk("reset_data", 64'(rg_wrt_data), 64'(0));
        chk("reset_gid", 64'(grant_id), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].a2,
                  vecs[i].d0, vecs[i].d1, vecs[i].d2);
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
            step();
            chk($sformatf("v%0d_we", i), 64'(RegWrite), 64'(vecs[i].exp_we));
            if (vecs[i].chk_bus) begin
                chk($sformatf("v%0d_dest", i), 64'(rg_wrt_dest), 64'(vecs[i].exp_dest));
                chk($sformatf("v%0d_data", i), 64'(rg_wrt_data), 64'(vecs[i].exp_data));
                chk($sformatf("v%0d_gid", i), 64'(grant_id), 64'(vecs[i].exp_gid));
            end
        end
        // rr_ptr is 0 here; the table's last write (dest 10) is visible now and clears nothing.
        drive(3'b000, 0, 0, 0, 0, 0, 0);

        // Scoreboard: reserve 7, then write it back.
        rsv_valid = 1'b1; rsv_dest = 5'd7;
        step();
        chk("sb_set7", 64'(busy), 64'(32'h80));
        rsv_valid = 1'b0;
        drive(3'b001, 7, 0, 0, 32'h77, 0, 0);
        #1;
        chk("sb_wb_ready", 64'(req_ready), 64'(3'b001));
        step();
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        chk("sb_wb_we", 64'(RegWrite), 64'(1));
        chk("sb_busy_during_we", 64'(busy), 64'(32'h80));
        step();
        chk("sb_clr7", 64'(busy), 64'(0));

        // Reserve 7 again, then re-reserve it while its old write retires.
        rsv_valid = 1'b1; rsv_dest = 5'd7;
        step();
        rsv_valid = 1'b0;
        drive(3'b010, 0, 7, 0, 0, 32'h78, 0);
        step();
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        chk("sb_we7_again", 64'({RegWrite, rg_wrt_dest}), 64'({1'b1, 5'd7}));
        rsv_valid = 1'b1; rsv_dest = 5'd7;
        step();
        rsv_valid = 1'b0;
        chk("sb_set_wins", 64'(busy), 64'(32'h80));
        step();
        chk("sb_set_holds", 64'(busy), 64'(32'h80));

        // x0 is never reserved.
        rsv_valid = 1'b1; rsv_dest = 5'd0;
        step();
        rsv_valid = 1'b0;
        chk("sb_x0_ignored", 64'(busy), 64'(32'h80));

        // Reset in the cycle after a handshake drops the pending write and clears busy.
        rsv_valid = 1'b1; rsv_dest = 5'd9;
        drive(3'b100, 0, 0, 9, 0, 0, 32'h99);
        step();
        rsv_valid = 1'b0;
        drive(3'b111, 1, 2, 3, 32'hF0, 32'hF1, 32'hF2);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 64'(req_ready), 64'(3'b000));
        chk("rst_mid_we_before", 64'(RegWrite), 64'(1));
        step();
        chk("rst_mid_we", 64'(RegWrite), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        #1;
        chk("rst_rr_ptr0", 64'(req_ready), 64'(3'b001));
        step();
        chk("rst_first_grant", 64'({RegWrite, grant_id, rg_wrt_dest}), 64'({1'b1, 2'd0, 5'd1}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
